// File: rtl/seq_mult_param_if.sv
// Handshake and operand/result bundle for the parametrised sequential multiplier.
interface seq_mult_param_if #(
  parameter int unsigned WIDTH = 24
);
  logic                   start;
  logic                   signed_mode;
  logic                   abort;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic [2*WIDTH-1:0]     ResultBus;
  logic                   ready;
  logic                   busy;
  logic                   done;

  modport master (
    output start, signed_mode, abort, A, B,
    input  ResultBus, ready, busy, done
  );

  modport slave (
    input  start, signed_mode, abort, A, B,
    output ResultBus, ready, busy, done
  );
endinterface

// File: rtl/seq_mult_param.sv
// Shift-add multiplier, one multiplier bit per clock, LSB first; signed operands
// are multiplied as magnitudes and the sign is applied in a final FIX cycle.
module seq_mult_param #(
  parameter int unsigned WIDTH = 24
) (
  input logic              clk,
  input logic              rst,
  seq_mult_param_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_nx;
  logic                 neg;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   result;
  logic                 done_q;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       psum;
  logic                 last;

  always_comb begin
    mag_a = (bus.signed_mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    mag_b = (bus.signed_mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    // Multiplier bits sit in the low half of acc and are consumed from bit 0.
    psum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = CALC;
      CALC: begin
        if (bus.abort)  state_nx = IDLE;
        else if (last)  state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg    <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg   <= bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            mcand <= mag_a;
            acc   <= {{WIDTH{1'b0}}, mag_b};
            cnt   <= '0;
          end
        end
        CALC: begin
          if (!bus.abort) begin
            acc <= {psum, acc[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          if (!bus.abort) begin
            result <= neg ? -acc : acc;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ResultBus = result;
  assign bus.ready     = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// Directed-vector bench for seq_mult_param at WIDTH=24 and WIDTH=4.
module tb_seq_mult_param;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seq_mult_param_if #(.WIDTH(24)) bus24 ();
  seq_mult_param_if #(.WIDTH(4))  bus4 ();

  seq_mult_param #(.WIDTH(24)) dut24 (.clk(clk), .rst(rst), .bus(bus24));
  seq_mult_param #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller is #1 after a rising edge; returns #1 after the edge that raised done.
  task automatic run24(input logic [23:0] a, input logic [23:0] b, input logic sm,
                       output logic [47:0] res, output int lat);
    bus24.A = a; bus24.B = b; bus24.signed_mode = sm; bus24.start = 1'b1;
    @(posedge clk); #1;
    bus24.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus24.done) begin lat = n; break; end
    end
    res = bus24.ResultBus;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                      output logic [7:0] res, output int lat);
    bus4.A = a; bus4.B = b; bus4.signed_mode = sm; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus4.done) begin lat = n; break; end
    end
    res = bus4.ResultBus;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus24.start = 1'b0; bus24.abort = 1'b0; bus24.signed_mode = 1'b0; bus24.A = '0; bus24.B = '0;
    bus4.start = 1'b0;  bus4.abort = 1'b0;  bus4.signed_mode = 1'b0;  bus4.A = '0;  bus4.B = '0;
    #2;
    checks++; if (bus24.ResultBus !== 48'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus24.ResultBus); end
    checks++; if (bus24.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus24.ready); end
    checks++; if (bus24.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus24.busy); end
    checks++; if (bus24.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus24.done); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [47:0] r; int l;
    run24(24'd11, 24'd3, 1'b0, r, l);
    checks++; if (l !== 25) begin failures++; $display("FAIL u_latency got=%0d exp=25", l); end
    checks++; if (r !== 48'd33) begin failures++; $display("FAIL u_11x3 got=%h exp=%h", r, 48'd33); end
    checks++; if (bus24.ready !== 1'b1) begin failures++; $display("FAIL u_ready_in_done got=%b exp=1", bus24.ready); end
    @(posedge clk); #1;
    checks++; if (bus24.done !== 1'b0) begin failures++; $display("FAIL u_done_pulse got=%b exp=0", bus24.done); end
  endtask

  task automatic test_signed();
    logic [47:0] r; int l;
    run24(24'hFFFFFB, 24'd3, 1'b1, r, l);
    checks++; if (r !== 48'hFFFF_FFFF_FFF1) begin failures++; $display("FAIL s_m5x3 got=%h exp=ffffffffff f1", r); end
    run24(24'hFFFFFB, 24'hFFFFFD, 1'b1, r, l);
    checks++; if (r !== 48'd15) begin failures++; $display("FAIL s_m5xm3 got=%h exp=%h", r, 48'd15); end
  endtask

  task automatic test_extremes();
    logic [47:0] r; int l;
    run24(24'h800000, 24'h800000, 1'b1, r, l);
    checks++; if (r !== 48'h4000_0000_0000) begin failures++; $display("FAIL s_minneg_sq got=%h exp=400000000000", r); end
    run24(24'hFFFFFF, 24'hFFFFFF, 1'b0, r, l);
    checks++; if (r !== 48'hFFFF_FE00_0001) begin failures++; $display("FAIL u_max_sq got=%h exp=fffffe000001", r); end
  endtask

  task automatic test_back_to_back();
    int l;
    bus24.A = 24'd7; bus24.B = 24'd9; bus24.signed_mode = 1'b0; bus24.start = 1'b1;
    @(posedge clk); #1;
    bus24.start = 1'b0;
    l = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == 5) begin bus24.A = 24'd2; bus24.B = 24'd2; bus24.start = 1'b1; end
      else        bus24.start = 1'b0;
      @(posedge clk); #1;
      if (bus24.done) begin l = n; break; end
    end
    bus24.start = 1'b0;
    checks++; if (l !== 25) begin failures++; $display("FAIL busy_start_latency got=%0d exp=25", l); end
    checks++; if (bus24.ResultBus !== 48'd63) begin failures++; $display("FAIL busy_start_result got=%h exp=%h", bus24.ResultBus, 48'd63); end
    // Start issued in the done cycle.
    bus24.A = 24'd2; bus24.B = 24'd2; bus24.start = 1'b1;
    @(posedge clk); #1;
    bus24.start = 1'b0;
    checks++; if (bus24.busy !== 1'b1 || bus24.done !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b done=%b exp busy=1 done=0", bus24.busy, bus24.done); end
    l = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus24.done) begin l = n; break; end
    end
    checks++; if (l !== 25) begin failures++; $display("FAIL b2b_latency got=%0d exp=25", l); end
    checks++; if (bus24.ResultBus !== 48'd4) begin failures++; $display("FAIL b2b_result got=%h exp=%h", bus24.ResultBus, 48'd4); end
  endtask

  task automatic test_abort();
    logic [47:0] r; int l; int dones;
    run24(24'd11, 24'd3, 1'b0, r, l);
    checks++; if (r !== 48'd33) begin failures++; $display("FAIL abort_prior got=%h exp=%h", r, 48'd33); end
    bus24.A = 24'd100; bus24.B = 24'd100; bus24.start = 1'b1;
    @(posedge clk); #1;
    bus24.start = 1'b0;
    for (int n = 1; n < 10; n++) begin @(posedge clk); #1; end
    bus24.abort = 1'b1; bus24.start = 1'b1; bus24.A = 24'd5; bus24.B = 24'd5;
    @(posedge clk); #1;
    bus24.abort = 1'b0; bus24.start = 1'b0;
    checks++; if (bus24.ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", bus24.ready); end
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus24.done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    checks++; if (bus24.ResultBus !== 48'd33) begin failures++; $display("FAIL abort_hold got=%h exp=%h", bus24.ResultBus, 48'd33); end
  endtask

  task automatic test_reset_mid();
    int dones;
    bus24.A = 24'd100; bus24.B = 24'd100; bus24.start = 1'b1;
    @(posedge clk); #1;
    bus24.start = 1'b0;
    for (int n = 0; n < 5; n++) begin @(posedge clk); #1; end
    #2; rst = 1'b0; #1;
    checks++; if (bus24.ResultBus !== 48'd0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", bus24.ResultBus); end
    checks++; if (bus24.ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus24.ready); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus24.done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_width4();
    logic [7:0] r; int l;
    run4(4'hF, 4'hF, 1'b0, r, l);
    checks++; if (l !== 5) begin failures++; $display("FAIL w4_latency got=%0d exp=5", l); end
    checks++; if (r !== 8'hE1) begin failures++; $display("FAIL w4_15x15 got=%h exp=e1", r); end
    run4(4'h8, 4'h7, 1'b1, r, l);
    checks++; if (r !== 8'hC8) begin failures++; $display("FAIL w4_m8x7 got=%h exp=c8", r); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
